// File: rtl/d2s_converter_if.sv
// Bundles the generator-facing inputs and display-facing outputs of d2s_converter.
interface d2s_converter_if #(
  parameter int unsigned Size   = 5,
  parameter int unsigned Digits = 2
);
  logic [Size-1:0]     Data;
  logic                SigneBit;
  logic [7*Digits-1:0] Segments;
  logic [6:0]          SignSegments;
  logic                Busy;
  logic                Update;

  modport master (
    output Data, SigneBit,
    input  Segments, SignSegments, Busy, Update
  );

  modport slave (
    input  Data, SigneBit,
    output Segments, SignSegments, Busy, Update
  );
endinterface

// File: rtl/d2s_converter.sv
// Sign-magnitude binary to seven-segment display driver with a sequential
// double-dabble BCD engine and leading-zero blanking.
module d2s_converter #(
  parameter int unsigned Size   = 5,
  parameter int unsigned Digits = 2,
  parameter string       Signed = "No"
) (
  input  logic            Clock,
  input  logic            Reset,
  d2s_converter_if.slave  bus
);

  localparam int unsigned BcdW = 4 * Digits;
  localparam int unsigned SegW = 7 * Digits;
  localparam int unsigned CntW = $clog2(Size + 1);
  localparam bit          SignEn = (Signed == "Yes");

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegMinus = 7'b0111111;
  localparam logic [6:0] SegZero  = 7'b1000000;
  localparam logic [SegW-1:0] SegRst = ({SegW{1'b1}} << 7) | SegW'(SegZero);

  // Digit count must cover the largest magnitude Data can carry.
  if ((10 ** Digits) <= (2 ** Size) - 1) begin : g_range_err
    $error("d2s_converter: Digits too small for Size");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [Size-1:0]     bin_q, bin_d;
  logic [Size:0]       cap_q, cap_d;
  logic [Size:0]       last_q, last_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [SegW-1:0]     seg_q, seg_d;
  logic [6:0]          sign_seg_q, sign_seg_d;
  logic                busy_q, busy_d;
  logic                update_q, update_d;

  logic [BcdW-1:0]     adj;
  logic [SegW-1:0]     enc;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SegBlank;
    endcase
  endfunction

  // Add-3 correction applied to every BCD nibble before each shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < int'(Digits); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Segment encoding with blanking of leading zero digits above digit 0.
  always_comb begin
    logic nz;
    nz  = 1'b0;
    enc = {SegW{1'b1}};
    for (int i = int'(Digits) - 1; i >= 0; i--) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        nz = 1'b1;
      end
      if (i == 0 || nz) begin
        enc[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
      end else begin
        enc[7*i +: 7] = SegBlank;
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    cap_d      = cap_q;
    last_d     = last_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    seg_d      = seg_q;
    sign_seg_d = sign_seg_q;
    busy_d     = busy_q;
    update_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if ({bus.Data, bus.SigneBit} != last_q) begin
          bin_d   = bus.Data;
          cap_d   = {bus.Data, bus.SigneBit};
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {adj[BcdW-2:0], bin_q[Size-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(Size - 1)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        seg_d = enc;
        if (SignEn && cap_q[0] && (cap_q[Size:1] != '0)) begin
          sign_seg_d = SegMinus;
        end else begin
          sign_seg_d = SegBlank;
        end
        last_d   = cap_q;
        update_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      cap_q      <= '0;
      last_q     <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      seg_q      <= SegRst;
      sign_seg_q <= SegBlank;
      busy_q     <= 1'b0;
      update_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      cap_q      <= cap_d;
      last_q     <= last_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      seg_q      <= seg_d;
      sign_seg_q <= sign_seg_d;
      busy_q     <= busy_d;
      update_q   <= update_d;
    end
  end

  assign bus.Segments     = seg_q;
  assign bus.SignSegments = sign_seg_q;
  assign bus.Busy         = busy_q;
  assign bus.Update       = update_q;

endmodule

// File: doc/d2s_converter.md
# d2s_converter

Display stage directly downstream of the data generator: takes the generator's `Data` magnitude and `SigneBit` and drives a bank of static seven-segment digits plus a sign digit. Each input change is converted to BCD by a sequential shift-add-3 (double-dabble) engine, then encoded to segments with leading-zero blanking. All display outputs update atomically, only after a conversion completes. An `Update` pulse marks each refresh.

## Interface
- `Size`, 5, width of `Data`; must match the generator's `Size`.
- `Digits`, 2, number of decimal digits. Elaboration `$error` if `10**Digits <= 2**Size-1`.
- `Signed`, "No", "Yes" enables the sign digit; "No" forces the sign digit blank.
- `Clock`, input, 1, system clock, all state on rising edge.
- `Reset`, input, 1, asynchronous, active-high.
- `Data`, input, Size, unsigned magnitude from the generator.
- `SigneBit`, input, 1, 1 = negative, sign-magnitude with `Data`.
- `Segments`, output, 7*Digits, active-low segments. Digit i (i=0 is least significant) occupies bits [7i+6:7i], ordered {g,f,e,d,c,b,a}.
- `SignSegments`, output, 7, active-low sign digit, same bit order.
- `Busy`, output, 1, high while a conversion is in progress.
- `Update`, output, 1, one-cycle pulse on the cycle the display outputs change.

## Operation
- Segment codes (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - minus=0111111, blank=1111111
- `Last` register holds the {Data,SigneBit} value currently displayed. Reset value 0.
- FSM states IDLE, SHIFT, LOAD.
  - IDLE: if {Data,SigneBit} != Last, capture `Data` into Bin and `SigneBit` into SignCap. Clear the BCD register (4*Digits bits) and step counter, then go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {BCD,Bin} left by 1 and increment the counter. After Size shifts, go to LOAD.
  - LOAD: encode the BCD digits. Register `Segments`/`SignSegments`, set Last = captured value, pulse `Update`, return to IDLE.
- Blanking: digit i>0 is blank if it and every higher digit are 0. Digit 0 is never blank. Internal zeros are shown (100 displays as 1,0,0).
- Sign: minus only if Signed=="Yes", SignCap=1 and captured value != 0. Otherwise blank (no "-0").
- Input changes during SHIFT/LOAD are ignored by the running conversion. IDLE re-detects the mismatch on the next cycle and starts a new conversion, so the newest value is always displayed eventually.
- Inputs are synchronous to `Clock`; no input synchronizers are required.

## Timing
- Reset (asynchronous, immediate) values:
  - state IDLE; `Busy`=0, `Update`=0, Last=0.
  - `Segments`: digit0=1000000, all other digits blank.
  - `SignSegments`=1111111.
- Reset asserted mid-conversion aborts the conversion; outputs go to reset values at once. After release, a mismatch with Last triggers a new conversion normally.
- Capture at edge k (IDLE->SHIFT). `Busy`=1 from edge k.
- Shifts occur at edges k+1..k+Size; LOAD is entered at edge k+Size.
- At edge k+Size+1: display outputs update, `Update`=1 for that cycle only, `Busy`=0, state IDLE.
- Latency: Size+1 cycles from capture to display; capture one cycle after the input change is visible at an edge in IDLE.
- Back-to-back: the earliest next capture is edge k+Size+2, giving a throughput of one conversion per Size+2 cycles.
- No change on inputs means no activity: `Busy` and `Update` stay 0.

## Test plan
- Reset, Data=0, SigneBit=0, release → digit0=1000000, digit1=1111111, SignSegments=1111111. `Busy` never rises.
- Size=5/Digits=2, Data=27 at capture edge k → `Busy` high k..k+5. At k+6: digit1=0100100, digit0=1111000, one-cycle `Update`.
- Signed="Yes", Data=5, SigneBit=1 → digit0=0010010, digit1 blank, SignSegments=0111111. Then Data=0, SigneBit=1 → digit0=1000000, sign blank.
- Data=12, then change to 31 two cycles after capture → 12 displayed first (`Update` pulse). Next capture at the following edge; 31 displayed Size+1 cycles later with a second `Update`.
- Reset asserted during SHIFT → immediate reset outputs, `Busy`=0. Release with Data=9 → display 9 after Size+2 cycles.
- Size=8/Digits=3: Data=255 → 2,5,5; Data=100 → 1,0,0; Data=7 → blank, blank, 7.
